// File: rtl/wb_arbiter2.sv
// wb_arbiter2 -- two-master, one-slave Wishbone arbiter with bus lock,
// round-robin tie breaking and a slave-response timeout.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   m0_* / m1_*             master-side Wishbone ports (m0 = host, m1 = DMA):
//                           cyc/stb/we/sel/adr/dat in, dat/ack/err out
//   s_*                     shared slave Wishbone port: cyc/stb/we/sel/adr/dat
//                           out, dat/ack in
//   gnt_o                   one-hot current owner (01 = m0, 10 = m1, 00 = idle)
//
// Ownership is held for as long as the owner keeps cyc asserted, and one
// idle cycle always separates two tenures. If the owner's strobe sits
// unacknowledged for TIMEOUT+1 cycles, the owner gets a one-cycle err and
// the slave strobe is suppressed for that cycle.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // master 0
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // shared slave
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  // owner indication
  output logic [1:0]    gnt_o
);

  localparam int              CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;     // last granted master, 1 after reset so m0 wins first tie
  logic [CW-1:0] r_cnt;      // cycles the current strobe has waited for ack

  logic w_req0;
  logic w_req1;
  logic w_own_stb;
  logic w_timeout;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

  // Owner strobe before timeout suppression; zero in IDLE.
  always_comb begin
    w_own_stb = 1'b0;
    case (r_state)
      OWN0:    w_own_stb = m0_stb_i;
      OWN1:    w_own_stb = m1_stb_i;
      default: w_own_stb = 1'b0;
    endcase
  end

  // An ack in the limit cycle wins over the timeout.
  assign w_timeout = w_own_stb & ~s_ack_i & (r_cnt == TO_VAL);

  // ---- state register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == OWN0) begin
        r_last <= 1'b0;
      end else if (r_state == IDLE && w_next == OWN1) begin
        r_last <= 1'b1;
      end
      // Cleared on idle, no strobe, ack, or the timeout itself.
      if (r_state == IDLE || !w_own_stb || s_ack_i || w_timeout) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          w_next = r_last ? OWN0 : OWN1;
        end else if (w_req0) begin
          w_next = OWN0;
        end else if (w_req1) begin
          w_next = OWN1;
        end
      end
      // Dropping cyc always passes through IDLE, never straight to the other owner.
      OWN0:    if (!m0_cyc_i) w_next = IDLE;
      OWN1:    if (!m1_cyc_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    gnt_o    = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (r_state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~w_timeout;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_timeout;
        m0_dat_o = s_dat_i;
        gnt_o    = 2'b01;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~w_timeout;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_timeout;
        m1_dat_o = s_dat_i;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2 -- self-checking bench for wb_arbiter2 (TIMEOUT=4).
// Masters are driven by tasks that push the expected response into a
// per-master queue; a monitor pops and compares whenever a master sees
// ack or err. A behavioural slave acks after a programmable number of
// strobe cycles and returns data computed from the address.
module tb_wb_arbiter2;

  localparam logic [31:0] BAD = 32'h0BAD_0BAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cyc, stb, we;
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] m0_dat, m1_dat;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        sl_cyc, sl_stb, sl_we, sl_ack;
  logic [3:0]  sl_sel;
  logic [31:0] sl_adr, sl_wdat, sl_rdat;
  logic [1:0]  gnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [1:0] glog[$];

  int slv_wait  = 2;
  bit slv_rand  = 1'b0;
  bit slv_never = 1'b0;
  bit slv_stray = 1'b0;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o (sl_cyc), .s_stb_o(sl_stb), .s_we_o(sl_we), .s_sel_o(sl_sel),
    .s_adr_o (sl_adr), .s_dat_o(sl_wdat), .s_dat_i(sl_rdat), .s_ack_i(sl_ack),
    .gnt_o   (gnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {~a[31:16], a[15:0] ^ 16'h5A5A};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] glog_at(input int i);
    return (i < glog.size()) ? glog[i] : 2'b11;
  endfunction

  // Behavioural slave: acks after slv_wait strobe cycles (random 1..4 in random mode).
  initial begin
    int cnt, tgt;
    logic seen, aseen;
    logic [31:0] a;
    sl_ack = 1'b0; sl_rdat = BAD; cnt = 0; tgt = slv_wait;
    forever begin
      @(negedge clk);
      seen = sl_cyc & sl_stb; aseen = sl_ack; a = sl_adr;
      @(posedge clk); #1;
      sl_ack = 1'b0; sl_rdat = BAD;
      if (rst) begin
        cnt = 0;
      end else if (slv_stray) begin
        sl_ack = 1'b1; sl_rdat = 32'h1234_5678; cnt = 0;
      end else if (!seen || aseen) begin
        cnt = 0; tgt = slv_rand ? $urandom_range(1, 4) : slv_wait;
      end else begin
        cnt++;
        if (cnt >= tgt && !slv_never) begin
          sl_ack = 1'b1; sl_rdat = rdata(a); cnt = 0;
        end
      end
    end
  end

  // Grant history, consecutive duplicates collapsed.
  initial begin
    logic [1:0] glast;
    glast = 2'b00;
    forever begin
      @(negedge clk);
      if (gnt !== glast) begin
        glog.push_back(gnt);
        glast = gnt;
      end
    end
  end

  task automatic score(input int m);
    exp_t e;
    logic ack, err, oresp;
    logic [31:0] d, od;
    ack   = (m == 0) ? m0_ack : m1_ack;
    err   = (m == 0) ? m0_err : m1_err;
    d     = (m == 0) ? m0_dat : m1_dat;
    od    = (m == 0) ? m1_dat : m0_dat;
    oresp = (m == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err);
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      checks++; failures++;
      $display("FAIL m%0d_unexpected_resp: actual ack=%b err=%b required none", m, ack, err);
    end else begin
      e = (m == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("m%0d_ack", m), 32'(ack), 32'(!e.err));
      chk($sformatf("m%0d_err", m), 32'(err), 32'(e.err));
      if (!e.err) chk($sformatf("m%0d_rdat", m), d, e.rd);
      chk($sformatf("m%0d_s_stb", m), 32'(sl_stb), 32'(!e.err));
      chk($sformatf("m%0d_s_adr", m), sl_adr, e.adr);
      chk($sformatf("m%0d_s_we", m), 32'(sl_we), 32'(e.we));
      chk($sformatf("m%0d_s_sel", m), 32'(sl_sel), 32'(e.sel));
      if (e.we) chk($sformatf("m%0d_s_wdat", m), sl_wdat, e.wd);
      chk($sformatf("m%0d_gnt", m), 32'(gnt), (m == 0) ? 1 : 2);
      chk($sformatf("m%0d_other_quiet", m), 32'(oresp), 0);
      chk($sformatf("m%0d_other_dat", m), od, 0);
    end
  endtask

  // Monitor: bus-level invariants and scoreboard pops.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("gnt_legal", 32'(gnt == 2'b11), 0);
      if (gnt == 2'b00) begin
        chk("idle_quiet", 32'({sl_cyc, sl_stb, sl_we, sl_sel, m0_ack, m1_ack, m0_err, m1_err}), 0);
        chk("idle_adr", sl_adr | sl_wdat | m0_dat | m1_dat, 0);
      end
      if (m0_ack | m0_err) score(0);
      if (m1_ack | m1_err) score(1);
    end
  end

  task automatic m_drive(input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; wdat[m] = d; sel[m] = s;
  endtask

  task automatic m_push(input int m, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit e_err);
    exp_t e;
    e.adr = a; e.we = w; e.sel = s; e.wd = d; e.rd = rdata(a); e.err = e_err;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic m_finish(input int m, input bit keep);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk); n++;
      done = (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
    end
    chk($sformatf("m%0d_resp_in_time", m), 32'(done), 1);
    @(posedge clk); #1;
    stb[m] = 1'b0;
    if (!keep) begin
      cyc[m] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic m_xfer(input int m, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit keep);
    m_push(m, w, a, d, s, 1'b0);
    m_drive(m, w, a, d, s);
    m_finish(m, keep);
  endtask

  task automatic wait_gnt(input logic [1:0] g);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt !== g && n < 50);
    chk("wait_gnt", 32'(gnt), 32'(g));
  endtask

  task automatic idle_sync();
    repeat (2) @(negedge clk);
    glog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_master(input int m);
    for (int t = 0; t < 12; t++) begin
      int len;
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++)
        m_xfer(m, 1'($urandom_range(0, 1)), $urandom, $urandom,
               4'($urandom_range(1, 15)), b < len - 1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    logic [1:0] nz[$];
    cyc = '0; stb = '0; we = '0;
    for (int i = 0; i < 2; i++) begin sel[i] = '0; adr[i] = '0; wdat[i] = '0; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_slave", 32'({sl_cyc, sl_stb, sl_we, sl_sel}), 0);
    chk("rst_resp", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
    chk("rst_buses", sl_adr | sl_wdat | m0_dat | m1_dat, 0);
    rst = 1'b0;

    // Single read from m0: grant one cycle after request
    @(posedge clk); #1;
    slv_wait = 2;
    m_push(0, 1'b0, 32'h3004_0010, 32'h0, 4'hF, 1'b0);
    m_drive(0, 1'b0, 32'h3004_0010, 32'h0, 4'hF);
    @(negedge clk);
    chk("lat_req_gnt", 32'(gnt), 0);
    chk("lat_req_cyc", 32'(sl_cyc), 0);
    @(negedge clk);
    chk("lat_gnt", 32'(gnt), 1);
    chk("lat_cyc", 32'(sl_cyc), 1);
    chk("lat_adr", sl_adr, 32'h3004_0010);
    m_finish(0, 1'b0);

    // Stray slave ack while idle
    idle_sync();
    slv_stray = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray_resp", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
    chk("stray_dat", m0_dat | m1_dat, 0);
    slv_stray = 1'b0;

    // Simultaneous writes after reset: m0, idle, m1
    do_reset();
    idle_sync();
    fork
      m_xfer(0, 1'b1, 32'h0000_1000, 32'hA5A5_0001, 4'hF, 1'b0);
      m_xfer(1, 1'b1, 32'h0000_2000, 32'h5A5A_0002, 4'h3, 1'b0);
    join
    chk("rr_seq0", 32'(glog_at(0)), 1);
    chk("rr_seq1", 32'(glog_at(1)), 0);
    chk("rr_seq2", 32'(glog_at(2)), 2);

    // Bus lock: m1 keeps cyc over three strobes while m0 waits
    idle_sync();
    fork
      begin
        m_xfer(1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 1'b1);
        m_xfer(1, 1'b1, 32'h0000_3004, 32'hCAFE_0001, 4'hC, 1'b1);
        m_xfer(1, 1'b0, 32'h0000_3008, 32'h0, 4'hF, 1'b0);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        m_xfer(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 1'b0);
      end
    join
    chk("lock_seq0", 32'(glog_at(0)), 2);
    chk("lock_seq1", 32'(glog_at(1)), 0);
    chk("lock_seq2", 32'(glog_at(2)), 1);

    // Fairness: both request continuously, 8 tenures alternate
    do_reset();
    idle_sync();
    fork
      for (int i = 0; i < 4; i++) m_xfer(0, 1'b0, $urandom, 32'h0, 4'hF, 1'b0);
      for (int i = 0; i < 4; i++) m_xfer(1, 1'b1, $urandom, $urandom, 4'hF, 1'b0);
    join
    foreach (glog[i]) if (glog[i] != 2'b00) nz.push_back(glog[i]);
    chk("fair_count", nz.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fair_tenure%0d", i), 32'((i < nz.size()) ? nz[i] : 2'b11),
          (i % 2 == 0) ? 1 : 2);

    // Timeout: no ack, err on strobe cycles 5 and 10 while stb stays high
    idle_sync();
    slv_never = 1'b1;
    m_push(0, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 1'b1);
    m_push(0, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 1'b1);
    m_drive(0, 1'b0, 32'h0000_7000, 32'h0, 4'hF);
    wait_gnt(2'b01);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("to_err_c%0d", k), 32'(m0_err), 32'(k == 5 || k == 10));
      chk($sformatf("to_stb_c%0d", k), 32'(sl_stb), 32'(!(k == 5 || k == 10)));
    end
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    slv_never = 1'b0;
    slv_wait = 4;
    idle_sync();
    // Ack lands in the limit cycle: ack only
    m_xfer(0, 1'b0, 32'h0000_7100, 32'h0, 4'hF, 1'b0);
    slv_wait = 2;

    // Reset in the middle of an m1 transfer
    idle_sync();
    slv_never = 1'b1;
    m_drive(1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    wait_gnt(2'b10);
    chk("prerst_stb", 32'(sl_stb), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_now_cyc", 32'({sl_cyc, sl_stb}), 0);
    chk("rst_now_gnt", 32'(gnt), 0);
    chk("rst_now_resp", 32'({m1_ack, m1_err}), 0);
    m_drive(0, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
    slv_never = 1'b0;
    slv_wait = 1;
    m_push(0, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 1'b0);
    m_push(1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk("inrst_gnt", 32'(gnt), 0);
    chk("inrst_slave", 32'({sl_cyc, sl_stb, sl_we, sl_sel}), 0);
    chk("inrst_resp", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
    chk("inrst_buses", sl_adr | sl_wdat | m0_dat | m1_dat, 0);
    @(negedge clk);
    glog.delete();
    rst = 1'b0;
    m_finish(0, 1'b0);
    m_finish(1, 1'b0);
    chk("post_rst_seq0", 32'(glog_at(0)), 1);
    chk("post_rst_seq1", 32'(glog_at(1)), 0);
    chk("post_rst_seq2", 32'(glog_at(2)), 2);

    // Randomized traffic from both masters
    idle_sync();
    slv_rand = 1'b1;
    fork
      rand_master(0);
      rand_master(1);
    join
    slv_rand = 1'b0;
    idle_sync();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
